// File: rtl/lmdpl_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// lmdpl_ctrl_pkg
// Shared types and constants for the LMDPL phase sequencer:
//   state_e    - sequencer FSM states (Idle, Mask, Pre, Eval, Done)
//   LFSR_W     - width of the internal mask LFSR
//   LFSR_TAPS  - Galois feedback taps of the mask LFSR
//   mask_sel() - maps an all-zero seed to 1 so the LFSR cannot lock up
// -----------------------------------------------------------------------------
package lmdpl_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StMask,
        StPre,
        StEval,
        StDone
    } state_e;

    localparam int unsigned       LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    // An all-zero Galois LFSR never leaves zero; substitute 1.
    function automatic logic [LFSR_W-1:0] mask_sel(input logic [LFSR_W-1:0] seed);
        return (seed == '0) ? LFSR_W'(1) : seed;
    endfunction

endpackage

// File: rtl/lmdpl_mask_lfsr.sv
// -----------------------------------------------------------------------------
// lmdpl_mask_lfsr
// 16-bit Galois LFSR (taps LFSR_TAPS) that steps on every clock outside reset.
// Ports:
//   clk      in   1       clock
//   rst_n    in   1       asynchronous active-low reset, loads the guarded seed
//   i_seed   in   LFSR_W  reset value (zero is replaced by 1); tie to a constant
//   o_lfsr_q out  OUT_W   low OUT_W bits of the current LFSR state
// -----------------------------------------------------------------------------
module lmdpl_mask_lfsr
    import lmdpl_ctrl_pkg::*;
#(
    parameter int unsigned OUT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LFSR_W-1:0] i_seed,
    output logic [OUT_W-1:0]  o_lfsr_q
);

    logic [LFSR_W-1:0] r_lfsr;
    logic [LFSR_W-1:0] w_lfsr_next;

    // Right-shifting Galois form: taps are XORed in when the bit shifted out is 1.
    always_comb begin
        w_lfsr_next = r_lfsr >> 1;
        if (r_lfsr[0]) begin
            w_lfsr_next = w_lfsr_next ^ LFSR_TAPS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= mask_sel(i_seed);
        end else begin
            r_lfsr <= w_lfsr_next;
        end
    end

    assign o_lfsr_q = r_lfsr[OUT_W-1:0];

endmodule

// File: rtl/lmdpl_phase_sequencer.sv
// -----------------------------------------------------------------------------
// lmdpl_phase_sequencer
// Drives a bank of LMDPL masked dual-rail gates through precharge/evaluate.
// One op per valid/ready handshake: load fresh masks while precharged, hold
// precharge for PRE_CYCLES, evaluate for EVAL_CYCLES (capture_en in the last
// one), then pulse done with precharge already restored.
//
// Configuration macro: LMDPL_EXT_RND_EN
//   defined   - i_rnd_in port exists, masks are sampled from it, no LFSR
//   undefined - masks come from the internal lmdpl_mask_lfsr
//
// Ports:
//   clk          in   1       clock
//   rst_n        in   1       asynchronous active-low reset
//   i_op_valid   in   1       request one evaluate phase
//   o_op_ready   out  1       op can be accepted (Idle/Done and no abort)
//   i_abort      in   1       synchronous abort back to Idle, precharged
//   o_precharge  out  1       1 = gate inputs forced to 0, 0 = evaluate
//   o_mask       out  MASK_W  gate masks; only change while precharged
//   o_capture_en out  1       high in the final evaluate cycle
//   o_done       out  1       one-cycle pulse after capture
//   o_busy       out  1       high in any state other than Idle
//   i_rnd_in     in   MASK_W  external randomness (LMDPL_EXT_RND_EN only)
// -----------------------------------------------------------------------------
module lmdpl_phase_sequencer
    import lmdpl_ctrl_pkg::*;
#(
    parameter int unsigned       PRE_CYCLES  = 1,
    parameter int unsigned       EVAL_CYCLES = 2,
    parameter int unsigned       MASK_W      = 8,
    parameter logic [LFSR_W-1:0] LFSR_SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_op_valid,
    output logic              o_op_ready,
    input  logic              i_abort,
    output logic              o_precharge,
    output logic [MASK_W-1:0] o_mask,
    output logic              o_capture_en,
    output logic              o_done,
    output logic              o_busy
`ifdef LMDPL_EXT_RND_EN
    ,
    input  logic [MASK_W-1:0] i_rnd_in
`endif
);

    localparam int unsigned CNT_MAX = (PRE_CYCLES > EVAL_CYCLES) ? PRE_CYCLES : EVAL_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PRE_LOAD  = CNT_W'(PRE_CYCLES - 1);
    localparam logic [CNT_W-1:0] EVAL_LOAD = CNT_W'(EVAL_CYCLES - 1);

    state_e            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_precharge;
    logic [MASK_W-1:0] r_mask;
    logic              r_capture;
    logic              r_done;
    logic [MASK_W-1:0] w_mask_src;

`ifdef LMDPL_EXT_RND_EN
    assign w_mask_src = i_rnd_in;
`else
    lmdpl_mask_lfsr #(
        .OUT_W (MASK_W)
    ) u_mask_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_seed   (LFSR_SEED),
        .o_lfsr_q (w_mask_src)
    );
`endif

    // Outputs are registered alongside the state so precharge never glitches
    // and capture_en/done line up exactly with the Eval/Done cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_precharge <= 1'b1;
            r_mask      <= '0;
            r_capture   <= 1'b0;
            r_done      <= 1'b0;
        end else if (i_abort) begin
            // Mask deliberately held; the aborted op produces no done pulse.
            r_state     <= StIdle;
            r_precharge <= 1'b1;
            r_capture   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_precharge <= 1'b1;
            r_capture   <= 1'b0;
            r_done      <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_op_valid) begin
                        r_state <= StMask;
                    end
                end
                StMask: begin
                    r_mask  <= w_mask_src;
                    r_cnt   <= PRE_LOAD;
                    r_state <= StPre;
                end
                StPre: begin
                    if (r_cnt == '0) begin
                        r_state     <= StEval;
                        r_cnt       <= EVAL_LOAD;
                        r_precharge <= 1'b0;
                        r_capture   <= (EVAL_CYCLES == 1);
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                StEval: begin
                    if (r_cnt == '0) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt       <= r_cnt - CNT_W'(1);
                        r_precharge <= 1'b0;
                        r_capture   <= (r_cnt == CNT_W'(1));
                    end
                end
                StDone: begin
                    r_state <= i_op_valid ? StMask : StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_op_ready   = ((r_state == StIdle) || (r_state == StDone)) && !i_abort;
    assign o_busy       = (r_state != StIdle);
    assign o_precharge  = r_precharge;
    assign o_mask       = r_mask;
    assign o_capture_en = r_capture;
    assign o_done       = r_done;

endmodule
